msft_dv_debug_apb_arbiter: RTL and testbench

//  N-master to 1-slave APB arbiter for the debug APB fabric; replaces static select muxing.

---
 rtl/msft_dv_debug_apb_arbiter_if.sv | 47 ++++
 rtl/msft_dv_debug_apb_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_msft_dv_debug_apb_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/msft_dv_debug_apb_arbiter_if.sv
// APB bundle for the debug fabric arbiter.
// Upstream side: NUM_MST packed master buses (master m at slice m).
// Downstream side: the single shared slave bus.
// Modport "slave" is the arbiter's view: it is the slave of the upstream
// masters and drives the downstream bus. Modport "master" is the view of
// whatever surrounds the arbiter (debug masters plus the downstream slave).
interface msft_dv_debug_apb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MST    = 3
);

  // upstream, one lane per master
  logic [NUM_MST-1:0]            psel_i;
  logic [NUM_MST-1:0]            penable_i;
  logic [NUM_MST*ADDR_WIDTH-1:0] paddr_i;
  logic [NUM_MST*DATA_WIDTH-1:0] pwdata_i;
  logic [NUM_MST-1:0]            pwrite_i;
  logic [DATA_WIDTH-1:0]         prdata_o;
  logic [NUM_MST-1:0]            pready_o;
  logic [NUM_MST-1:0]            psuberr_o;

  // downstream, single slave bus
  logic                          psel_out_o;
  logic                          penable_out_o;
  logic [ADDR_WIDTH-1:0]         paddr_out_o;
  logic [DATA_WIDTH-1:0]         pwdata_out_o;
  logic                          pwrite_out_o;
  logic [DATA_WIDTH-1:0]         prdata_out_i;
  logic                          pready_out_i;
  logic                          psuberr_out_i;

  modport slave (
    input  psel_i, penable_i, paddr_i, pwdata_i, pwrite_i,
    output prdata_o, pready_o, psuberr_o,
    output psel_out_o, penable_out_o, paddr_out_o, pwdata_out_o, pwrite_out_o,
    input  prdata_out_i, pready_out_i, psuberr_out_i
  );

  modport master (
    output psel_i, penable_i, paddr_i, pwdata_i, pwrite_i,
    input  prdata_o, pready_o, psuberr_o,
    input  psel_out_o, penable_out_o, paddr_out_o, pwdata_out_o, pwrite_out_o,
    output prdata_out_i, pready_out_i, psuberr_out_i
  );

endinterface

// File: rtl/msft_dv_debug_apb_arbiter.sv
// N-master to 1-slave APB arbiter for the debug APB fabric.
// Round-robin grant (searching from the last winner + 1), registered
// downstream SETUP/ACCESS sequence, optional fixed-select override.
// Every transfer is followed by one IDLE cycle, so back-to-back grants are
// three cycles apart.
//
// Build option: define MSFT_APB_ARB_TIMEOUT_EN to enable the ACCESS-phase
// watchdog. When it reaches TIMEOUT_CYCLES the granted master receives
// pready+psuberr with zero read data and the downstream bus is released.
// Without the macro ACCESS waits indefinitely and TIMEOUT_CYCLES is only
// range-checked.
module msft_dv_debug_apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_MST        = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  msft_dv_debug_apb_arbiter_if.slave apb,
  input  logic                       fixed_sel_en_i,
  input  logic [$clog2(NUM_MST)-1:0] fixed_sel_i,
  output logic [NUM_MST-1:0]         grant_o
);

  localparam int IDX_W = $clog2(NUM_MST);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // Elaboration-time guard on the supported configuration range.
  if (NUM_MST < 2 || NUM_MST > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("msft_dv_debug_apb_arbiter: NUM_MST must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  logic [1:0]            state_q, state_d;
  logic [NUM_MST-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      gidx_q, gidx_d;
  logic                  psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;

  logic [NUM_MST-1:0]    eligible;
  logic                  win_found;
  logic [IDX_W-1:0]      win_idx;
  logic                  in_access;
  logic                  timeout_hit;
  logic                  xfer_done;

  assign in_access = (state_q == ST_ACCESS);

`ifdef MSFT_APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog fires on the TIMEOUT_CYCLES-th ACCESS cycle unless the slave answers in it.
  assign timeout_hit = in_access && !apb.pready_out_i &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter clears while in SETUP and counts stalled ACCESS cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = '0;
    end else if (in_access && !apb.pready_out_i && !timeout_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_done = in_access && (apb.pready_out_i || timeout_hit);

  // Eligible requesters: all psel lanes, or only the fixed lane when the override is on.
  // An out-of-range fixed index leaves nobody eligible.
  always_comb begin
    eligible = apb.psel_i;
    if (fixed_sel_en_i) begin
      eligible = '0;
      if (int'(fixed_sel_i) < NUM_MST) begin
        eligible[fixed_sel_i] = apb.psel_i[fixed_sel_i];
      end
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = (int'(ptr_q) + k) % NUM_MST;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic for the IDLE -> SETUP -> ACCESS -> IDLE sequence.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    psel_d   = psel_q;
    pen_d    = pen_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_SETUP;
          grant_d  = {{(NUM_MST-1){1'b0}}, 1'b1} << win_idx;
          gidx_d   = win_idx;
          psel_d   = 1'b1;
          pen_d    = 1'b0;
          paddr_d  = apb.paddr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          pwdata_d = apb.pwdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          pwrite_d = apb.pwrite_i[win_idx];
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        pen_d   = 1'b1;
      end
      ST_ACCESS: begin
        // Address/data stay frozen until the slave (or the watchdog) ends the transfer.
        if (xfer_done) begin
          state_d = ST_IDLE;
          psel_d  = 1'b0;
          pen_d   = 1'b0;
          grant_d = '0;
          ptr_d   = gidx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        psel_d  = 1'b0;
        pen_d   = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  // State and downstream bus registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      ptr_q    <= IDX_W'(NUM_MST - 1);
      gidx_q   <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
    end
  end

  // Response routing: only the granted master, only in ACCESS, and only if it
  // is still in its enable phase. Reset suppresses the response of an aborted transfer.
  always_comb begin
    apb.pready_o  = '0;
    apb.psuberr_o = '0;
    if (in_access && !rst_i) begin
      if (apb.pready_out_i || timeout_hit) begin
        apb.pready_o = grant_q & apb.penable_i;
      end
      if ((apb.pready_out_i && apb.psuberr_out_i) || timeout_hit) begin
        apb.psuberr_o = grant_q & apb.penable_i;
      end
    end
  end

  assign apb.prdata_o      = timeout_hit ? '0 : apb.prdata_out_i;
  assign apb.psel_out_o    = psel_q;
  assign apb.penable_out_o = pen_q;
  assign apb.paddr_out_o   = paddr_q;
  assign apb.pwdata_out_o  = pwdata_q;
  assign apb.pwrite_out_o  = pwrite_q;
  assign grant_o           = grant_q;

endmodule

// File: tb/tb_msft_dv_debug_apb_arbiter.sv
// Directed bench for msft_dv_debug_apb_arbiter (3 masters, TIMEOUT_CYCLES=8).
// A cycle table covers arbitration; hand sequences cover wait states,
// the watchdog (or its absence) and reset during ACCESS.
module tb_msft_dv_debug_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 3;
  localparam int TO = 8;
`ifdef MSFT_APB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       fen;
  logic [1:0] fsel;
  logic [2:0] grant;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] mst_addr [3];
  logic [31:0] mst_wdat [3];

  msft_dv_debug_apb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MST(NM)) bus ();

  msft_dv_debug_apb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MST(NM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .apb            (bus),
    .fixed_sel_en_i (fen),
    .fixed_sel_i    (fsel),
    .grant_o        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] psel;
    logic [2:0] pen;
    logic       rdy;
    logic       err;
    logic       fen;
    logic [1:0] fsel;
    logic [2:0] e_gnt;
    logic       e_ps;
    logic       e_pe;
    logic [2:0] e_rdy;
    logic [2:0] e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(logic r, logic [2:0] ps, logic [2:0] pe, logic rdy, logic err,
                             logic f, logic [1:0] fs, logic [2:0] eg, logic eps, logic epe,
                             logic [2:0] erd, logic [2:0] eer);
    vec_t v;
    v.rst = r; v.psel = ps; v.pen = pe; v.rdy = rdy; v.err = err; v.fen = f; v.fsel = fs;
    v.e_gnt = eg; v.e_ps = eps; v.e_pe = epe; v.e_rdy = erd; v.e_err = eer;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] ps, input logic [2:0] pe,
                       input logic rdy, input logic err, input logic f, input logic [1:0] fs,
                       input logic [31:0] rdat);
    rst = r; bus.psel_i = ps; bus.penable_i = pe; bus.pready_out_i = rdy;
    bus.psuberr_out_i = err; fen = f; fsel = fs; bus.prdata_out_i = rdat;
  endtask

  function automatic int oh2idx(logic [2:0] oh);
    for (int m = 0; m < 3; m++) if (oh[m]) return m;
    return 0;
  endfunction

  initial begin
    mst_addr[0] = 32'h0000_0A00; mst_wdat[0] = 32'hA5A5_0000;
    mst_addr[1] = 32'h0000_0100; mst_wdat[1] = 32'hA5A5_0001;
    mst_addr[2] = 32'h0000_0C20; mst_wdat[2] = 32'hA5A5_0002;
    bus.paddr_i  = {mst_addr[2], mst_addr[1], mst_addr[0]};
    bus.pwdata_i = {mst_wdat[2], mst_wdat[1], mst_wdat[0]};
    bus.pwrite_i = 3'b010;
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);

    // single write, m1
    tbl.push_back(V(0, 3'b010, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b010, 3'b010, 0, 0, 0, 0, 3'b010, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b010, 3'b010, 1, 0, 0, 0, 3'b010, 1, 1, 3'b010, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // reset, then three-way contention with a zero-wait slave
    tbl.push_back(V(1, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b000, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b010, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b010, 1, 1, 3'b010, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b100, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b100, 1, 1, 3'b100, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // slave error on m2; error outside ACCESS must not leak
    tbl.push_back(V(0, 3'b100, 3'b000, 0, 1, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b100, 3'b100, 0, 1, 0, 0, 3'b100, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b100, 3'b100, 1, 1, 0, 0, 3'b100, 1, 1, 3'b100, 3'b100));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // fixed mode on m2 with m0 also requesting, then override released
    tbl.push_back(V(0, 3'b101, 3'b000, 1, 0, 1, 2, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 1, 2, 3'b100, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 1, 2, 3'b100, 1, 1, 3'b100, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 1, 2, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 1, 2, 3'b100, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 1, 2, 3'b100, 1, 1, 3'b100, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b101, 3'b101, 1, 0, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // out-of-range fixed index: nobody eligible
    tbl.push_back(V(0, 3'b111, 3'b000, 0, 0, 1, 3, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 1, 3, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b111, 3'b111, 1, 0, 1, 3, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // m1 abandons its transfer in ACCESS: downstream completes, response dropped
    tbl.push_back(V(0, 3'b010, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b010, 3'b010, 0, 0, 0, 0, 3'b010, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b010, 1, 1, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 1, 0, 0, 0, 3'b010, 1, 1, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // fixed-select change mid-transfer does not abort m0
    tbl.push_back(V(0, 3'b001, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b001, 3'b001, 0, 0, 1, 2, 3'b001, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b001, 3'b001, 1, 0, 1, 2, 3'b001, 1, 1, 3'b001, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    // reset during ACCESS: no response, everything idle next cycle
    tbl.push_back(V(0, 3'b001, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 1, 0, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 1, 1, 3'b000, 3'b000));
    tbl.push_back(V(1, 3'b001, 3'b001, 1, 0, 0, 0, 3'b001, 1, 1, 3'b000, 3'b000));
    tbl.push_back(V(0, 3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant",  {29'd0, grant}, 32'd0);
    chk("reset psel",   {31'd0, bus.psel_out_o}, 32'd0);
    chk("reset pen",    {31'd0, bus.penable_out_o}, 32'd0);
    chk("reset paddr",  bus.paddr_out_o, 32'd0);
    chk("reset pwdata", bus.pwdata_out_o, 32'd0);
    chk("reset pwrite", {31'd0, bus.pwrite_out_o}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].rst, tbl[i].psel, tbl[i].pen, tbl[i].rdy, tbl[i].err,
            tbl[i].fen, tbl[i].fsel, 32'hC0DE_0000 | i);
      @(negedge clk);
      chk($sformatf("v%0d grant", i),   {29'd0, grant}, {29'd0, tbl[i].e_gnt});
      chk($sformatf("v%0d psel", i),    {31'd0, bus.psel_out_o}, {31'd0, tbl[i].e_ps});
      chk($sformatf("v%0d penable", i), {31'd0, bus.penable_out_o}, {31'd0, tbl[i].e_pe});
      chk($sformatf("v%0d pready", i),  {29'd0, bus.pready_o}, {29'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d psuberr", i), {29'd0, bus.psuberr_o}, {29'd0, tbl[i].e_err});
      if (tbl[i].e_ps) begin
        chk($sformatf("v%0d paddr", i),  bus.paddr_out_o, mst_addr[oh2idx(tbl[i].e_gnt)]);
        chk($sformatf("v%0d pwdata", i), bus.pwdata_out_o, mst_wdat[oh2idx(tbl[i].e_gnt)]);
        chk($sformatf("v%0d pwrite", i), {31'd0, bus.pwrite_out_o},
            (oh2idx(tbl[i].e_gnt) == 1) ? 32'd1 : 32'd0);
      end
      if (tbl[i].e_rdy != 3'b000) begin
        chk($sformatf("v%0d prdata", i), bus.prdata_o, 32'hC0DE_0000 | i);
      end
    end

    // wait states: m0 read, slave stalls 5 ACCESS cycles then returns 0xDEADBEEF
    @(posedge clk); #1; drive(0, 3'b001, 3'b000, 0, 0, 0, 0, 32'h0);
    @(negedge clk); chk("ws idle grant", {29'd0, grant}, 32'd0);
    @(posedge clk); #1; drive(0, 3'b001, 3'b001, 0, 0, 0, 0, 32'h0);
    @(negedge clk); chk("ws setup grant", {29'd0, grant}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1; drive(0, 3'b001, 3'b001, 0, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("ws%0d penable", k), {31'd0, bus.penable_out_o}, 32'd1);
      chk($sformatf("ws%0d paddr", k), bus.paddr_out_o, 32'h0000_0A00);
      chk($sformatf("ws%0d pwdata", k), bus.pwdata_out_o, 32'hA5A5_0000);
      chk($sformatf("ws%0d pwrite", k), {31'd0, bus.pwrite_out_o}, 32'd0);
      chk($sformatf("ws%0d pready", k), {29'd0, bus.pready_o}, 32'd0);
    end
    @(posedge clk); #1; drive(0, 3'b001, 3'b001, 1, 0, 0, 0, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("ws done pready", {29'd0, bus.pready_o}, 32'd1);
    chk("ws done prdata", bus.prdata_o, 32'hDEAD_BEEF);
    chk("ws done paddr", bus.paddr_out_o, 32'h0000_0A00);
    @(posedge clk); #1; drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("ws after psel", {31'd0, bus.psel_out_o}, 32'd0);
    chk("ws after grant", {29'd0, grant}, 32'd0);

    // unresponsive slave on m1: watchdog fires on ACCESS cycle 8 when enabled
    @(posedge clk); #1; drive(0, 3'b010, 3'b000, 0, 0, 0, 0, 32'h1234_5678);
    @(posedge clk); #1; drive(0, 3'b010, 3'b010, 0, 0, 0, 0, 32'h1234_5678);
    @(negedge clk); chk("to setup grant", {29'd0, grant}, 32'd2);
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1; drive(0, 3'b010, 3'b010, 0, 0, 0, 0, 32'h1234_5678);
      @(negedge clk);
      chk($sformatf("to%0d penable", k), {31'd0, bus.penable_out_o}, 32'd1);
      chk($sformatf("to%0d pready", k), {29'd0, bus.pready_o},
          (TO_EN && k == TO) ? 32'd2 : 32'd0);
      chk($sformatf("to%0d psuberr", k), {29'd0, bus.psuberr_o},
          (TO_EN && k == TO) ? 32'd2 : 32'd0);
      chk($sformatf("to%0d prdata", k), bus.prdata_o,
          (TO_EN && k == TO) ? 32'h0 : 32'h1234_5678);
    end
    @(posedge clk); #1; drive(0, 3'b010, 3'b010, 0, 0, 0, 0, 32'h1234_5678);
    @(negedge clk);
    chk("to next psel", {31'd0, bus.psel_out_o}, TO_EN ? 32'd0 : 32'd1);
    chk("to next grant", {29'd0, grant}, TO_EN ? 32'd0 : 32'd2);
    chk("to next pready", {29'd0, bus.pready_o}, 32'd0);

    // reset clears whatever is in flight, with the slave answering in the reset cycle
    @(posedge clk); #1; drive(1, 3'b010, 3'b010, 1, 1, 0, 0, 32'h1234_5678);
    @(negedge clk);
    chk("rst cycle pready", {29'd0, bus.pready_o}, 32'd0);
    chk("rst cycle psuberr", {29'd0, bus.psuberr_o}, 32'd0);
    @(posedge clk); #1; drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("post rst grant", {29'd0, grant}, 32'd0);
    chk("post rst psel", {31'd0, bus.psel_out_o}, 32'd0);
    chk("post rst penable", {31'd0, bus.penable_out_o}, 32'd0);
    chk("post rst paddr", bus.paddr_out_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
